// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types and helpers for the global history register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    localparam int GHR_HIST_MAX = 32;
    localparam int GHR_NUM_CKPT = 8;
    localparam int GHR_TAG_W    = $clog2(GHR_NUM_CKPT);

    typedef logic [GHR_TAG_W-1:0] ghr_tag_t;

    // Callers pass histories zero-extended to GHR_HIST_MAX and truncate the
    // result back to their own length, which discards the old MSB.
    function automatic logic [GHR_HIST_MAX-1:0] ghr_shift(
        input logic [GHR_HIST_MAX-1:0] hist,
        input logic                    taken
    );
        return (hist << 1) | GHR_HIST_MAX'(taken);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ghr_ckpt_buf.sv
// ============================================================================
// Module      : ghr_ckpt_buf
// Description : Per-branch history checkpoints plus head/tail/count tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghr_ckpt_buf #(
    parameter int DEPTH    = 4,
    parameter int NUM_CKPT = 8,
    parameter int TAG_W    = $clog2(NUM_CKPT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_data,
    input  logic [TAG_W-1:0] rd_tag,
    output logic [DEPTH-1:0] rd_data,
    input  logic             rec_en,
    input  logic             commit_en,
    input  logic             flush,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             ready
);

    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0] r_ckpt [NUM_CKPT];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [TAG_W-1:0] w_head_next;
    logic [CNT_W-1:0] w_rec_count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_ckpt[r_tail] <= wr_data;
        end
    end

    assign rd_data     = r_ckpt[rd_tag];
    assign w_head_next = r_head + TAG_W'(commit_en);
    // Recovered branch itself stays in flight, hence the +1.
    assign w_rec_count = {1'b0, rd_tag - r_head} + CNT_W'(1) - CNT_W'(commit_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head <= w_head_next;
            if (flush) begin
                r_tail  <= w_head_next;
                r_count <= '0;
            end else if (rec_en) begin
                r_tail  <= rd_tag + TAG_W'(1);
                r_count <= w_rec_count;
            end else begin
                r_tail  <= r_tail + TAG_W'(wr_en);
                r_count <= r_count + CNT_W'(wr_en) - CNT_W'(commit_en);
            end
        end
    end

    assign head  = r_head;
    assign tail  = r_tail;
    assign count = r_count;
    assign empty = (r_count == '0);
    assign ready = (r_count < CNT_W'(NUM_CKPT));

endmodule

`default_nettype wire

// File: rtl/ghr_spec.sv
// ============================================================================
// Module      : ghr_spec
// Description : Speculative global history register with checkpointed
//               misprediction recovery and a committed architectural copy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghr_spec
    import rv32i_types::*;
#(
    parameter int DEPTH    = 4,
    parameter int NUM_CKPT = 8,
    parameter int TAG_W    = $clog2(NUM_CKPT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    output logic [TAG_W-1:0] pred_tag,
    input  logic             recover_valid,
    input  logic [TAG_W-1:0] recover_tag,
    input  logic             recover_taken,
    input  logic             commit_valid,
    input  logic             commit_taken,
    input  logic             flush,
    output logic [DEPTH-1:0] spec_hist,
    output logic [DEPTH-1:0] arch_hist,
    output logic [TAG_W:0]   count,
    output logic             empty
);

    localparam int CNT_W = TAG_W + 1;

    logic [DEPTH-1:0] r_spec;
    logic [DEPTH-1:0] r_arch;
    logic [DEPTH-1:0] w_spec_next;
    logic [DEPTH-1:0] w_arch_next;
    logic [DEPTH-1:0] w_ckpt_rd;
    logic [TAG_W-1:0] w_head;
    logic [TAG_W-1:0] w_tail;
    logic [TAG_W-1:0] w_rec_off;
    logic             w_accept;
    logic             w_recover;
    logic             w_commit;

    assign w_accept  = pred_valid && pred_ready && !flush && !recover_valid;
    assign w_recover = recover_valid && !flush;
    assign w_commit  = commit_valid && !empty;

    ghr_ckpt_buf #(
        .DEPTH    (DEPTH),
        .NUM_CKPT (NUM_CKPT),
        .TAG_W    (TAG_W)
    ) u_ckpt_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_accept),
        .wr_data   (r_spec),
        .rd_tag    (recover_tag),
        .rd_data   (w_ckpt_rd),
        .rec_en    (w_recover),
        .commit_en (w_commit),
        .flush     (flush),
        .head      (w_head),
        .tail      (w_tail),
        .count     (count),
        .empty     (empty),
        .ready     (pred_ready)
    );

    assign w_arch_next = w_commit ? DEPTH'(ghr_shift(GHR_HIST_MAX'(r_arch), commit_taken))
                                  : r_arch;

    always_comb begin
        w_spec_next = r_spec;
        if (rst) begin
            w_spec_next = '1;
        end else if (flush) begin
            w_spec_next = w_arch_next;
        end else if (w_recover) begin
            w_spec_next = DEPTH'(ghr_shift(GHR_HIST_MAX'(w_ckpt_rd), recover_taken));
        end else if (w_accept) begin
            w_spec_next = DEPTH'(ghr_shift(GHR_HIST_MAX'(r_spec), pred_taken));
        end
    end

    always_ff @(posedge clk) begin
        r_spec <= w_spec_next;
        if (rst) begin
            r_arch <= '1;
        end else begin
            r_arch <= w_arch_next;
        end
    end

    // Fetch consumes the post-update history in the same cycle.
    assign spec_hist = w_spec_next;
    assign arch_hist = r_arch;
    assign pred_tag  = w_tail;
    assign w_rec_off = recover_tag - w_head;

    a_rec_in_flight : assert property (@(posedge clk) disable iff (rst)
        w_recover |-> ({1'b0, w_rec_off} < count));
    a_commit_not_empty : assert property (@(posedge clk) disable iff (rst)
        commit_valid |-> !empty);
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(NUM_CKPT));

endmodule

`default_nettype wire

// File: tb/tb_ghr_spec.sv
// ============================================================================
// Module      : tb_ghr_spec
// Description : Self-checking bench for ghr_spec against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ghr_spec;

    localparam int DEPTH    = 4;
    localparam int NUM_CKPT = 4;
    localparam int TAG_W    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pred_valid = 1'b0;
    logic             pred_taken = 1'b0;
    logic             pred_ready;
    logic [TAG_W-1:0] pred_tag;
    logic             recover_valid = 1'b0;
    logic [TAG_W-1:0] recover_tag = '0;
    logic             recover_taken = 1'b0;
    logic             commit_valid = 1'b0;
    logic             commit_taken = 1'b0;
    logic             flush = 1'b0;
    logic [DEPTH-1:0] spec_hist;
    logic [DEPTH-1:0] arch_hist;
    logic [TAG_W:0]   count;
    logic             empty;

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight branches as a queue of their pre-shift history.
    bit [DEPTH-1:0] m_spec;
    bit [DEPTH-1:0] m_arch;
    bit [DEPTH-1:0] m_q[$];
    int             m_head;
    int             m_tail;

    ghr_spec #(
        .DEPTH    (DEPTH),
        .NUM_CKPT (NUM_CKPT),
        .TAG_W    (TAG_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .pred_tag      (pred_tag),
        .recover_valid (recover_valid),
        .recover_tag   (recover_tag),
        .recover_taken (recover_taken),
        .commit_valid  (commit_valid),
        .commit_taken  (commit_taken),
        .flush         (flush),
        .spec_hist     (spec_hist),
        .arch_hist     (arch_hist),
        .count         (count),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [DEPTH-1:0] hshift(input bit [DEPTH-1:0] h, input bit b);
        return bit'(b) | (h << 1);
    endfunction

    task automatic model_reset();
        m_spec = '1;
        m_arch = '1;
        m_q.delete();
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, "_arch"},  arch_hist, m_arch);
        check({pfx, "_count"}, count, m_q.size());
        check({pfx, "_empty"}, empty, m_q.size() == 0);
        check({pfx, "_ready"}, pred_ready, m_q.size() < NUM_CKPT);
        check({pfx, "_tag"},   pred_tag, m_tail);
    endtask

    // Inputs are applied at the next rising edge; spec_hist is checked now.
    task automatic step(input bit pv, input bit pt, input bit rv, input int rtag,
                        input bit rt, input bit cv, input bit ct, input bit fl);
        bit             accept;
        bit             commit;
        bit [DEPTH-1:0] spec_n;
        bit [DEPTH-1:0] arch_n;
        int             idx;
        @(posedge clk);
        #1;
        pred_valid    = pv;
        pred_taken    = pt;
        recover_valid = rv;
        recover_tag   = TAG_W'(rtag);
        recover_taken = rt;
        commit_valid  = cv;
        commit_taken  = ct;
        flush         = fl;
        #1;
        check_regs("st");
        accept = pv && (m_q.size() < NUM_CKPT) && !fl && !rv;
        commit = cv && (m_q.size() != 0);
        arch_n = commit ? hshift(m_arch, ct) : m_arch;
        spec_n = m_spec;
        if (fl) begin
            spec_n = arch_n;
            m_q.delete();
            if (commit) m_head = (m_head + 1) % NUM_CKPT;
            m_tail = m_head;
        end else begin
            if (rv) begin
                idx    = (rtag - m_head + NUM_CKPT) % NUM_CKPT;
                spec_n = hshift(m_q[idx], rt);
                while (m_q.size() > idx + 1) void'(m_q.pop_back());
                m_tail = (rtag + 1) % NUM_CKPT;
            end else if (accept) begin
                m_q.push_back(m_spec);
                spec_n = hshift(m_spec, pt);
                m_tail = (m_tail + 1) % NUM_CKPT;
            end
            if (commit) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % NUM_CKPT;
            end
        end
        check("st_spec", spec_hist, spec_n);
        m_spec = spec_n;
        m_arch = arch_n;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit noisy);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        pred_valid    = noisy;
        pred_taken    = 1'($urandom);
        recover_valid = noisy;
        recover_tag   = TAG_W'($urandom);
        commit_valid  = noisy;
        flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_spec", spec_hist, 4'b1111);
        check_regs("rst");
        rst           = 1'b0;
        pred_valid    = 1'b0;
        recover_valid = 1'b0;
        commit_valid  = 1'b0;
    endtask

    initial begin
        int rtag;
        bit cv;
        bit rv;
        model_reset();
        do_reset(0);

        // Basic prediction sequence
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("tp_spec0", spec_hist, 4'b1110);
        check("tp_tag0", pred_tag, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("tp_spec1", spec_hist, 4'b1100);
        check("tp_tag1", pred_tag, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("tp_spec2", spec_hist, 4'b1001);
        check("tp_tag2", pred_tag, 2);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("full_spec", spec_hist, 4'b0011);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("full_ready", pred_ready, 0);
        check("full_count", count, 4);
        check("full_hold", spec_hist, 4'b0011);
        idle();
        check("full_tail", pred_tag, 0);

        // Recovery, commit and wrap-around
        do_reset(0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0, 0);
        check("rec_spec", spec_hist, 4'b1101);
        idle();
        check("rec_count", count, 2);
        check("rec_tag", pred_tag, 2);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("cm_arch0", arch_hist, 4'b1110);
        idle();
        check("cm_arch1", arch_hist, 4'b1100);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("wr_tag2", pred_tag, 2);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("wr_tag3", pred_tag, 3);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("wr_tag0", pred_tag, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("wr_tag1", pred_tag, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("wr_rec_spec", spec_hist, 4'b1110);
        idle();
        check("wr_rec_count", count, 3);

        // Flush beats everything else that cycle
        step(1, 0, 1, 2, 0, 1, 1, 1);
        check("fl_spec", spec_hist, 4'b1001);
        idle();
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_arch", arch_hist, 4'b1001);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        do_reset(1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                rv   = (m_q.size() != 0) && ($urandom_range(0, 9) == 0);
                cv   = (m_q.size() != 0) && ($urandom_range(0, 9) < 3);
                rtag = (m_q.size() != 0)
                     ? (m_head + int'($urandom_range(0, m_q.size() - 1))) % NUM_CKPT : 0;
                step($urandom_range(0, 9) < 6, 1'($urandom), rv, rtag, 1'($urandom),
                     cv, 1'($urandom), $urandom_range(0, 29) == 0);
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
